// File: rtl/z80_stim_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : z80_stim_pkg
//  Purpose  : Shared types for the Z80 control-line stimulus generator
//             (channel modes and per-channel FSM states).
//  Revision : 1.0  initial release
// ============================================================================
package z80_stim_pkg;

  localparam int MODE_W = 2;

  // Channel operating mode, selected per start strobe
  typedef enum logic [1:0] {
    OFF      = 2'd0,
    ONESHOT  = 2'd1,
    PERIODIC = 2'd2,
    HOLD_ACK = 2'd3
  } stim_mode_t;

  // Per-channel sequencer state
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    ACTIVE = 2'd2,
    GAP    = 2'd3
  } stim_state_t;

endpackage : z80_stim_pkg
`default_nettype wire

// File: rtl/z80_stim_chan.sv
`default_nettype none
// ============================================================================
//  Module   : z80_stim_chan
//  Purpose  : One active-low stimulus channel: delay, pulse width, period,
//             pulse count and hold-until-acknowledge, with shadowed config.
//  Revision : 1.0  initial release
// ============================================================================
module z80_stim_chan
  import z80_stim_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             ack,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] count,
  output logic             nout,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  stim_state_t      state, state_n;
  stim_mode_t       mode_in;
  stim_mode_t       sh_mode, sh_mode_n;
  logic [CNT_W-1:0] sh_wload, sh_wload_n;   // width-1 (width 0 behaves as 1)
  logic [CNT_W-1:0] sh_pload, sh_pload_n;   // effective period-1
  logic [CNT_W-1:0] sh_count, sh_count_n;
  logic [CNT_W-1:0] tcnt, tcnt_n;           // delay count in DELAY, width count in ACTIVE
  logic [CNT_W-1:0] pcnt, pcnt_n;           // cycles until next assertion begins
  logic [CNT_W-1:0] pulses, pulses_n;       // saturating assertion counter
  logic             nout_r, nout_n;
  logic             done_r, done_n;
  logic             launch;

  logic [CNT_W-1:0] w_eff;
  logic [CNT_W-1:0] wload;
  logic [CNT_W-1:0] pload;

  assign mode_in = stim_mode_t'(mode);
  assign w_eff   = (width == '0) ? ONE : width;
  assign wload   = w_eff - ONE;
  // A period no longer than the pulse is stretched to width+1 so one high cycle remains
  assign pload   = (period <= w_eff) ? w_eff : (period - ONE);

  // State, counters, shadow config and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sh_mode  <= OFF;
      sh_wload <= '0;
      sh_pload <= '0;
      sh_count <= '0;
      tcnt     <= '0;
      pcnt     <= '0;
      pulses   <= '0;
      nout_r   <= 1'b1;
      done_r   <= 1'b0;
    end else begin
      state    <= state_n;
      sh_mode  <= sh_mode_n;
      sh_wload <= sh_wload_n;
      sh_pload <= sh_pload_n;
      sh_count <= sh_count_n;
      tcnt     <= tcnt_n;
      pcnt     <= pcnt_n;
      pulses   <= pulses_n;
      nout_r   <= nout_n;
      done_r   <= done_n;
    end
  end

  // Next-state and next-output decode; stop overrides every other event
  always_comb begin
    state_n    = state;
    sh_mode_n  = sh_mode;
    sh_wload_n = sh_wload;
    sh_pload_n = sh_pload;
    sh_count_n = sh_count;
    tcnt_n     = tcnt;
    pcnt_n     = pcnt;
    pulses_n   = pulses;
    nout_n     = nout_r;
    done_n     = 1'b0;
    launch     = 1'b0;

    if (stop) begin
      state_n = IDLE;
      nout_n  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start && (mode_in != OFF)) begin
            state_n    = DELAY;
            tcnt_n     = delay;
            pcnt_n     = '0;
            pulses_n   = '0;
            sh_mode_n  = mode_in;
            sh_wload_n = wload;
            sh_pload_n = pload;
            sh_count_n = count;
          end
        end
        DELAY: begin
          if (tcnt == '0) launch = 1'b1;
          else            tcnt_n = tcnt - ONE;
        end
        ACTIVE: begin
          if (pcnt != '0) pcnt_n = pcnt - ONE;
          if (sh_mode == HOLD_ACK) begin
            if (ack) begin
              state_n = IDLE;
              nout_n  = 1'b1;
              done_n  = 1'b1;
            end
          end else if (tcnt == '0) begin
            nout_n = 1'b1;
            if ((sh_mode == PERIODIC) && !((sh_count != '0) && (pulses >= sh_count))) begin
              state_n = GAP;
            end else begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end else begin
            tcnt_n = tcnt - ONE;
          end
        end
        GAP: begin
          if (pcnt == '0) launch = 1'b1;
          else            pcnt_n = pcnt - ONE;
        end
        default: state_n = IDLE;
      endcase

      if (launch) begin
        state_n  = ACTIVE;
        tcnt_n   = sh_wload;
        pcnt_n   = sh_pload;
        pulses_n = (pulses == MAX) ? pulses : (pulses + ONE);
        nout_n   = 1'b0;
      end
    end
  end

  assign nout = nout_r;
  assign done = done_r;
  assign busy = (state != IDLE);

endmodule : z80_stim_chan
`default_nettype wire

// File: rtl/z80_ctl_stim.sv
`default_nettype none
// ============================================================================
//  Module   : z80_ctl_stim
//  Purpose  : NUM_CH independent active-low Z80 control-line stimulus
//             channels sharing one nM1/nIORQ interrupt acknowledge term.
//  Revision : 1.0  initial release
// ============================================================================
module z80_ctl_stim
  import z80_stim_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    CLK,
  input  logic                    nRESET,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH*2-1:0]     cfg_mode,
  input  logic [NUM_CH*CNT_W-1:0] cfg_delay,
  input  logic [NUM_CH*CNT_W-1:0] cfg_width,
  input  logic [NUM_CH*CNT_W-1:0] cfg_period,
  input  logic [NUM_CH*CNT_W-1:0] cfg_count,
  input  logic                    nM1,
  input  logic                    nIORQ,
  output logic [NUM_CH-1:0]       nOUT,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done
);

  // Interrupt acknowledge cycle; only consumed by channels in HOLD_ACK ACTIVE
  logic ack;
  assign ack = ~nM1 & ~nIORQ;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    z80_stim_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk    (CLK),
      .rst_n  (nRESET),
      .start  (start[i]),
      .stop   (stop[i]),
      .ack    (ack),
      .mode   (cfg_mode[MODE_W*i +: MODE_W]),
      .delay  (cfg_delay[CNT_W*i +: CNT_W]),
      .width  (cfg_width[CNT_W*i +: CNT_W]),
      .period (cfg_period[CNT_W*i +: CNT_W]),
      .count  (cfg_count[CNT_W*i +: CNT_W]),
      .nout   (nOUT[i]),
      .busy   (busy[i]),
      .done   (done[i])
    );
  end

endmodule : z80_ctl_stim
`default_nettype wire

// File: tb/tb_z80_ctl_stim.sv
`default_nettype none
// ============================================================================
//  Module   : tb_z80_ctl_stim
//  Purpose  : Scoreboard bench for z80_ctl_stim. Stimulus pushes expected
//             output transitions (edge, channel, signal, value); a monitor
//             pops and compares each transition the DUT actually makes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_z80_ctl_stim;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int S_NOUT = 0;
  localparam int S_BUSY = 1;
  localparam int S_DONE = 2;

  typedef struct {
    int   cyc;
    int   ch;
    int   sig;
    logic val;
  } ev_t;

  logic                    clk;
  logic                    nreset;
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       stop;
  logic [NUM_CH*2-1:0]     cfg_mode;
  logic [NUM_CH*CNT_W-1:0] cfg_delay;
  logic [NUM_CH*CNT_W-1:0] cfg_width;
  logic [NUM_CH*CNT_W-1:0] cfg_period;
  logic [NUM_CH*CNT_W-1:0] cfg_count;
  logic                    nm1;
  logic                    niorq;
  logic [NUM_CH-1:0]       nout;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       done;

  ev_t  exp_q[$];
  int   edge_no = 0;
  int   tests_run = 0;
  int   fails = 0;
  bit   mon_en = 1'b1;
  logic prev [NUM_CH][3];

  z80_ctl_stim #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .CLK        (clk),
    .nRESET     (nreset),
    .start      (start),
    .stop       (stop),
    .cfg_mode   (cfg_mode),
    .cfg_delay  (cfg_delay),
    .cfg_width  (cfg_width),
    .cfg_period (cfg_period),
    .cfg_count  (cfg_count),
    .nM1        (nm1),
    .nIORQ      (niorq),
    .nOUT       (nout),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge numbering: the value sampled at a negedge is "after edge edge_no"
  always @(posedge clk) edge_no <= edge_no + 1;

  function automatic logic sig_val(input int ch, input int s);
    case (s)
      S_NOUT:  return nout[ch];
      S_BUSY:  return busy[ch];
      default: return done[ch];
    endcase
  endfunction

  task automatic push(input int ch, input int cyc, input int s, input logic v);
    ev_t e;
    e.cyc = cyc; e.ch = ch; e.sig = s; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Pops one expected transition per observed output change
  task automatic monitor_loop();
    for (int c = 0; c < NUM_CH; c++) begin
      prev[c][S_NOUT] = 1'b1;
      prev[c][S_BUSY] = 1'b0;
      prev[c][S_DONE] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int c = 0; c < NUM_CH; c++) begin
        for (int s = 0; s < 3; s++) begin
          logic cur;
          cur = sig_val(c, s);
          if (cur !== prev[c][s] && mon_en) begin
            tests_run++;
            if (exp_q.size() == 0) begin
              fails++;
              $display("FAIL unexpected ch%0d sig%0d: got %0b at edge %0d, required no change",
                       c, s, cur, edge_no);
            end else begin
              ev_t e;
              e = exp_q.pop_front();
              if (e.cyc != edge_no || e.ch != c || e.sig != s || e.val !== cur) begin
                fails++;
                $display("FAIL event: got ch%0d sig%0d=%0b at edge %0d, required ch%0d sig%0d=%0b at edge %0d",
                         c, s, cur, edge_no, e.ch, e.sig, e.val, e.cyc);
              end
            end
          end
          prev[c][s] = cur;
        end
      end
    end
  endtask

  task automatic set_cfg(input int ch, input logic [1:0] m, input int d, input int w,
                         input int p, input int n);
    cfg_mode[2*ch +: 2]           = m;
    cfg_delay[CNT_W*ch +: CNT_W]  = CNT_W'(d);
    cfg_width[CNT_W*ch +: CNT_W]  = CNT_W'(w);
    cfg_period[CNT_W*ch +: CNT_W] = CNT_W'(p);
    cfg_count[CNT_W*ch +: CNT_W]  = CNT_W'(n);
  endtask

  // Raise start[ch] before the next edge; returns that edge number
  task automatic strobe_on(input int ch, output int e);
    @(negedge clk);
    start[ch] = 1'b1;
    e = edge_no + 1;
  endtask

  task automatic wait_until(input int t);
    while (edge_no < t) @(negedge clk);
  endtask

  initial begin
    int e;
    nreset = 1'b0; start = '0; stop = '0; nm1 = 1'b1; niorq = 1'b1;
    cfg_mode = '0; cfg_delay = '0; cfg_width = '0; cfg_period = '0; cfg_count = '0;
    fork
      monitor_loop();
    join_none
    repeat (3) @(negedge clk);
    chk("reset_nout", int'(nout), 'hF);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    nreset = 1'b1;
    repeat (2) @(negedge clk);

    // ch0 ONESHOT delay=3 width=2
    set_cfg(0, 2'd1, 3, 2, 0, 0);
    strobe_on(0, e);
    push(0, e,     S_BUSY, 1'b1);
    push(0, e + 4, S_NOUT, 1'b0);
    push(0, e + 6, S_NOUT, 1'b1);
    push(0, e + 6, S_BUSY, 1'b0);
    push(0, e + 6, S_DONE, 1'b1);
    push(0, e + 7, S_DONE, 1'b0);
    @(negedge clk); start = '0;
    wait_until(e + 10);

    // ch1 PERIODIC delay=0 width=1 period=5 count=3
    set_cfg(1, 2'd2, 0, 1, 5, 3);
    strobe_on(1, e);
    push(1, e,      S_BUSY, 1'b1);
    push(1, e + 1,  S_NOUT, 1'b0);
    push(1, e + 2,  S_NOUT, 1'b1);
    push(1, e + 6,  S_NOUT, 1'b0);
    push(1, e + 7,  S_NOUT, 1'b1);
    push(1, e + 11, S_NOUT, 1'b0);
    push(1, e + 12, S_NOUT, 1'b1);
    push(1, e + 12, S_BUSY, 1'b0);
    push(1, e + 12, S_DONE, 1'b1);
    push(1, e + 13, S_DONE, 1'b0);
    @(negedge clk); start = '0;
    wait_until(e + 20);

    // ch2 HOLD_ACK delay=2 width=1; ack in DELAY ignored, ack at e+20 releases
    set_cfg(2, 2'd3, 2, 1, 0, 0);
    strobe_on(2, e);
    push(2, e,      S_BUSY, 1'b1);
    push(2, e + 3,  S_NOUT, 1'b0);
    push(2, e + 20, S_NOUT, 1'b1);
    push(2, e + 20, S_BUSY, 1'b0);
    push(2, e + 20, S_DONE, 1'b1);
    push(2, e + 21, S_DONE, 1'b0);
    @(negedge clk); start = '0; nm1 = 1'b0; niorq = 1'b0;
    @(negedge clk); nm1 = 1'b1; niorq = 1'b1;
    wait_until(e + 19);
    nm1 = 1'b0; niorq = 1'b0;
    @(negedge clk); nm1 = 1'b1; niorq = 1'b1;
    wait_until(e + 24);

    // ch3 PERIODIC count=0 period=4 width=6 -> effective period 7; stop at e+30
    set_cfg(3, 2'd2, 0, 6, 4, 0);
    strobe_on(3, e);
    push(3, e, S_BUSY, 1'b1);
    for (int k = 0; k < 4; k++) begin
      push(3, e + 1 + 7*k, S_NOUT, 1'b0);
      push(3, e + 7 + 7*k, S_NOUT, 1'b1);
    end
    push(3, e + 29, S_NOUT, 1'b0);
    push(3, e + 30, S_NOUT, 1'b1);
    push(3, e + 30, S_BUSY, 1'b0);
    @(negedge clk); start = '0;
    wait_until(e + 29);
    stop[3] = 1'b1;
    @(negedge clk); stop = '0;
    wait_until(e + 35);

    // start together with stop on idle ch0: nothing happens
    set_cfg(0, 2'd1, 1, 1, 0, 0);
    @(negedge clk); start[0] = 1'b1; stop[0] = 1'b1;
    @(negedge clk); start = '0; stop = '0;
    repeat (5) @(negedge clk);

    // retrigger on busy ch0 with width=9 is ignored; width 3 is kept
    set_cfg(0, 2'd1, 1, 3, 0, 0);
    strobe_on(0, e);
    push(0, e,     S_BUSY, 1'b1);
    push(0, e + 2, S_NOUT, 1'b0);
    push(0, e + 5, S_NOUT, 1'b1);
    push(0, e + 5, S_BUSY, 1'b0);
    push(0, e + 5, S_DONE, 1'b1);
    push(0, e + 6, S_DONE, 1'b0);
    @(negedge clk);
    cfg_width[0 +: CNT_W] = CNT_W'(9);
    start[0] = 1'b1;
    @(negedge clk); start = '0;
    wait_until(e + 9);

    // width=0 acts as 1; stop on the edge ACTIVE would end suppresses done
    set_cfg(0, 2'd1, 0, 0, 0, 0);
    strobe_on(0, e);
    push(0, e,     S_BUSY, 1'b1);
    push(0, e + 1, S_NOUT, 1'b0);
    push(0, e + 2, S_NOUT, 1'b1);
    push(0, e + 2, S_BUSY, 1'b0);
    @(negedge clk); start = '0;
    wait_until(e + 1);
    stop[0] = 1'b1;
    @(negedge clk); stop = '0;
    wait_until(e + 6);

    // all channels HOLD_ACK, then async reset mid-pulse
    for (int c = 0; c < NUM_CH; c++) set_cfg(c, 2'd3, 0, 1, 0, 0);
    @(negedge clk); start = '1; e = edge_no + 1;
    for (int c = 0; c < NUM_CH; c++) push(c, e, S_BUSY, 1'b1);
    for (int c = 0; c < NUM_CH; c++) push(c, e + 1, S_NOUT, 1'b0);
    @(negedge clk); start = '0;
    wait_until(e + 3);
    mon_en = 1'b0;
    #1 nreset = 1'b0;
    #1;
    chk("async_reset_nout", int'(nout), 'hF);
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_done", int'(done), 0);
    @(negedge clk); nreset = 1'b1;
    @(negedge clk); mon_en = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset_busy", int'(busy), 0);
    chk("post_reset_nout", int'(nout), 'hF);

    chk("expected_events_left", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule : tb_z80_ctl_stim
`default_nettype wire

// File: doc/z80_ctl_stim.md
Name: z80_ctl_stim

Overview:
- Synthesizable, parametrised generator of active-low Z80 control-line stimulus (nINT, nNMI, nWAIT, nBUSRQ, ...). It replaces ad-hoc, hard-coded "repeat(N) @(posedge clk)" stimulus.
- NUM_CH independent channels. Each has a programmable delay, pulse width, period, pulse count, and a hold-until-acknowledge mode for maskable interrupts.
- Sits beside z80_top_ifc_n in bench tops and FPGA debug builds. Outputs drive z80_if control inputs directly.

Parameters:
- NUM_CH, 4, number of independent stimulus channels (1..16)
- CNT_W, 16, width of delay/width/period/count fields and internal counters

Ports:
- CLK  in  1  system clock; all logic on rising edge
- nRESET  in  1  asynchronous, active-low reset
- start  in  NUM_CH  per-channel one-cycle start strobe
- stop  in  NUM_CH  per-channel abort strobe
- cfg_mode  in  NUM_CH x 2  per-channel mode: OFF=0, ONESHOT=1, PERIODIC=2, HOLD_ACK=3
- cfg_delay  in  NUM_CH x CNT_W  cycles from start to first assertion
- cfg_width  in  NUM_CH x CNT_W  assertion length in cycles (0 treated as 1)
- cfg_period  in  NUM_CH x CNT_W  assertion-to-assertion spacing (PERIODIC only)
- cfg_count  in  NUM_CH x CNT_W  number of pulses in PERIODIC; 0 = unlimited
- nM1  in  1  Z80 nM1 (acknowledge detect)
- nIORQ  in  1  Z80 nIORQ (acknowledge detect)
- nOUT  out  NUM_CH  active-low stimulus outputs, registered
- busy  out  NUM_CH  channel not IDLE
- done  out  NUM_CH  one-cycle pulse on natural completion

Behaviour:
- Reset (async, nRESET=0): every channel goes to IDLE. nOUT='1, busy='0, done='0, all counters 0. Reset mid-pulse deasserts nOUT immediately (asynchronously).
- Per-channel FSM states: IDLE, DELAY, ACTIVE, GAP.
- IDLE:
  - start=1 with mode!=OFF latches all cfg_* fields into shadow registers; the channel enters DELAY.
  - cfg_* changes after that start have no effect until the next start.
  - start with mode=OFF is ignored.
- Timing, with start sampled at edge E:
  - nOUT goes low after edge E+delay+1.
  - nOUT stays low for width cycles, then returns high.
  - delay=0 means low after edge E+1.
- ONESHOT: ACTIVE -> IDLE after width cycles. done pulses in the first IDLE cycle.
- PERIODIC:
  - ACTIVE -> GAP. The next assertion begins period cycles after the previous one began.
  - If period<=width, the effective period is width+1, which guarantees one high cycle.
  - After cfg_count assertions the channel returns to IDLE and done pulses. count=0 runs until stop.
- HOLD_ACK:
  - ACTIVE holds nOUT low regardless of width.
  - Acknowledge is nM1=0 AND nIORQ=0 sampled at an edge; nOUT goes high after that edge.
  - The channel then returns to IDLE and done pulses.
  - Ack seen in DELAY or GAP is ignored.
- Pulse counter: CNT_W bits, saturating; never wraps.
- stop=1 in any state: channel goes to IDLE next edge, nOUT high after that edge, done not asserted.
- stop and start in the same cycle: stop wins, channel stays or goes IDLE.
- start while busy: ignored; no retrigger and no shadow-register update.
- ACTIVE ending on the same edge as stop: treated as stop, so no done.
- Channels are fully independent. Ack is shared; every channel in HOLD_ACK ACTIVE releases on the same ack.
- No combinational path from any input to nOUT/busy/done.

Decomposition:
- Package z80_stim_pkg holds:
  - typedef enum logic[1:0] stim_mode_t {OFF, ONESHOT, PERIODIC, HOLD_ACK}
  - typedef enum logic[1:0] stim_state_t {IDLE, DELAY, ACTIVE, GAP}
- Sub-module z80_stim_chan: one channel FSM, its counters and shadow config, parametrised by CNT_W. The top instantiates it NUM_CH times via generate and builds the shared registered-free ack term (~nM1 & ~nIORQ).

Test Plan:
- Reset release, then ch0 ONESHOT, delay=3, width=2, start at edge 10 -> nOUT[0] low after edges 14 and 15, high after edge 16; done[0] high exactly one cycle; busy[0] high for edges 11..16.
- ch1 PERIODIC, delay=0, width=1, period=5, count=3, start at edge 0 -> nOUT[1] low in cycles after edges 1, 6 and 11 only; done[1] pulse after edge 12; no fourth pulse.
- ch2 HOLD_ACK, width=1, delay=2; drive nM1=nIORQ=0 at edge 20 -> nOUT[2] low from after edge 3 until after edge 20, then high; done[2] pulses once; ack at edge 1 (in DELAY) has no effect.
- ch3 PERIODIC count=0, period=4, width=6 -> effective period 7 with exactly one high cycle between pulses; stop at edge 30 -> nOUT[3] high after edge 30, busy low, no done.
- Simultaneous start+stop on IDLE ch0 -> stays IDLE. start on busy ch0 with new cfg_width=9 -> original width kept. Assert nRESET=0 mid-pulse on all channels -> nOUT='1 immediately and all FSMs IDLE.
